// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory bus between the CPU MEM
// stage (m0) and the debug/loader port (m1), one transaction in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mX_req/we/addr/wdata  master request bundle (held until mX_ack)
//   mX_ack/err/rdata      one-cycle completion, unmapped flag, read data
//   bus_we/addr/wdata     to the RAM/IO address decoder
//   bus_rdata             from the decoder read mux
//   busy                  high whenever a transaction is in progress
module mem_bus_arbiter #(
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        sel_q;
  logic        we_q;
  logic        err_q;
  logic        last_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        any_req;
  logic        gnt_sel;
  logic        gnt_we;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        is_ram;
  logic        is_io;
  logic [3:0]  gnt_cnt;

  assign any_req = m0_req | m1_req;

  // On a tie the master that did not win last time gets the bus.
  assign gnt_sel = (m0_req & m1_req) ? ~last_q : m1_req;

  assign gnt_we    = gnt_sel ? m1_we    : m0_we;
  assign gnt_addr  = gnt_sel ? m1_addr  : m0_addr;
  assign gnt_wdata = gnt_sel ? m1_wdata : m0_wdata;

  assign is_ram = (gnt_addr <= 32'h0000_00FF);
  assign is_io  = (gnt_addr >= 32'h0000_0100) &&
                  (gnt_addr <= 32'h0000_01FF);

  assign gnt_cnt = is_io  ? 4'(IO_WAIT)  :
                   is_ram ? 4'(RAM_WAIT) : 4'd0;

  always_comb begin
    state_d = state_q;
    bus_we  = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          bus_we  = we_q & ~err_q;
          state_d = ACK;
        end
      end
      ACK: begin
        m0_ack  = ~sel_q;
        m1_ack  = sel_q;
        m0_err  = ~sel_q & err_q;
        m1_err  = sel_q & err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        sel_q   <= gnt_sel;
        we_q    <= gnt_we;
        addr_q  <= gnt_addr;
        wdata_q <= gnt_wdata;
        cnt_q   <= gnt_cnt;
        err_q   <= ~(is_ram | is_io);
        last_q  <= gnt_sel;
      end
      if (state_q == ACCESS) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          rdata_q <= err_q ? 32'd0 : bus_rdata;
        end
      end
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
